// File: rtl/tb_resource_arbiter.sv
// Round-robin arbiter sharing one resource among NB_REQ requesters; optional watchdog via TB_ARB_TIMEOUT_EN.
// Latency: req sampled -> res_start next cycle, res_done -> rsp_valid 1 cycle; requesters wait (held req) while busy.
module tb_resource_arbiter #(
    parameter int NB_REQ     = 4,
    parameter int CMD_WIDTH  = 64,
    parameter int TMO_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NB_REQ-1:0]           req,
    input  logic [NB_REQ*CMD_WIDTH-1:0] cmd,
    output logic [NB_REQ-1:0]           grant,
    output logic [NB_REQ-1:0]           rsp_valid,
    output logic                        rsp_err,
    output logic                        res_start,
    output logic [CMD_WIDTH-1:0]        res_cmd,
    input  logic                        res_done,
    input  logic                        res_err,
    output logic                        busy
);

    localparam int IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        ptr, win_idx, sel_idx;
    logic                 sel_found;
    logic [NB_REQ-1:0]    grant_q;
    logic                 err_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 tmo_hit;

    // First set request at or above the pointer, wrapping past NB_REQ-1.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NB_REQ) idx = idx - NB_REQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

`ifdef TB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DONE && !res_done) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // A res_done on the expiry cycle takes precedence over the timeout.
    assign tmo_hit = (state == WAIT_DONE) && !res_done && (tmo_cnt == TW'(TMO_CYCLES - 1));

    always @(posedge clk) begin
        if (rst_n && tmo_hit) $error("tb_resource_arbiter: timeout on requester %0d", win_idx);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (sel_found) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_DONE;
            WAIT_DONE: if (res_done || tmo_hit) state_nxt = RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win_idx <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_q <= NB_REQ'(1) << sel_idx;
                        win_idx <= sel_idx;
                        cmd_q   <= cmd[int'(sel_idx)*CMD_WIDTH +: CMD_WIDTH];
                    end
                end
                WAIT_DONE: begin
                    if (res_done)     err_q <= res_err;
                    else if (tmo_hit) err_q <= 1'b1;
                end
                RESP: begin
                    grant_q <= '0;
                    ptr     <= (win_idx == IW'(NB_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant     = grant_q;
    assign rsp_valid = (state == RESP) ? grant_q : '0;
    assign rsp_err   = (state == RESP) && err_q;
    assign res_start = (state == ISSUE);
    assign res_cmd   = cmd_q;
    assign busy      = (state != IDLE);

endmodule
